// File: rtl/render_pkg.sv
`default_nettype none
// ============================================================================
// Module   : render_pkg
// Purpose  : Shared types and constants for the tile renderer.
// Revision : 1.0 - initial release
// ============================================================================
package render_pkg;

    // Bit positions inside the grid storage byte
    localparam int c_BIT_WALL  = 7;
    localparam int c_BIT_TANK1 = 6;
    localparam int c_BIT_TANK2 = 5;
    localparam int c_BIT_PROJ  = 4;

    localparam logic [1:0] c_DIR_UP    = 2'b00;
    localparam logic [1:0] c_DIR_DOWN  = 2'b01;
    localparam logic [1:0] c_DIR_LEFT  = 2'b10;
    localparam logic [1:0] c_DIR_RIGHT = 2'b11;

    localparam logic [2:0] c_DEF_BG    = 3'b000;
    localparam logic [2:0] c_DEF_WALL  = 3'b011;
    localparam logic [2:0] c_DEF_TANK1 = 3'b101;
    localparam logic [2:0] c_DEF_TANK2 = 3'b100;
    localparam logic [2:0] c_DEF_GUN   = 3'b011;
    localparam logic [2:0] c_DEF_PROJ  = 3'b110;

    typedef enum logic [1:0] {
        KIND_EMPTY = 2'd0,
        KIND_WALL  = 2'd1,
        KIND_TANK  = 2'd2,
        KIND_PROJ  = 2'd3
    } kind_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BODY = 2'd1,
        ST_GUN  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Takes the upper nibble (type bits) of the storage byte; wall wins, then tanks, then projectile
    function automatic kind_t decode_kind(input logic [3:0] type_bits);
        kind_t k;
        if (type_bits[c_BIT_WALL - 4])
            k = KIND_WALL;
        else if (type_bits[c_BIT_TANK1 - 4] || type_bits[c_BIT_TANK2 - 4])
            k = KIND_TANK;
        else if (type_bits[c_BIT_PROJ - 4])
            k = KIND_PROJ;
        else
            k = KIND_EMPTY;
        return k;
    endfunction

endpackage
`default_nettype wire

// File: rtl/tile_scan_counter.sv
`default_nettype none
// ============================================================================
// Module   : tile_scan_counter
// Purpose  : 2-D raster offset counter with loadable start/end rectangle.
// Revision : 1.0 - initial release
// ============================================================================
module tile_scan_counter #(
    parameter int W = 4
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         i_load,
    input  logic         i_step,
    input  logic [W-1:0] i_x_start,
    input  logic [W-1:0] i_x_end,
    input  logic [W-1:0] i_y_start,
    input  logic [W-1:0] i_y_end,
    output logic [W-1:0] o_x,
    output logic [W-1:0] o_y,
    output logic         o_last
);

    localparam logic [W-1:0] c_ONE = {{(W-1){1'b0}}, 1'b1};

    logic [W-1:0] r_x;
    logic [W-1:0] r_y;
    logic [W-1:0] r_x_start;
    logic [W-1:0] r_x_end;
    logic [W-1:0] r_y_end;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_x       <= '0;
            r_y       <= '0;
            r_x_start <= '0;
            r_x_end   <= '0;
            r_y_end   <= '0;
        end else if (i_load) begin
            r_x       <= i_x_start;
            r_y       <= i_y_start;
            r_x_start <= i_x_start;
            r_x_end   <= i_x_end;
            r_y_end   <= i_y_end;
        end else if (i_step) begin
            if (r_x == r_x_end) begin
                r_x <= r_x_start;
                r_y <= r_y + c_ONE;
            end else begin
                r_x <= r_x + c_ONE;
            end
        end
    end

    assign o_x    = r_x;
    assign o_y    = r_y;
    assign o_last = (r_x == r_x_end) && (r_y == r_y_end);

endmodule
`default_nettype wire

// File: rtl/tile_renderer.sv
`default_nettype none
// ============================================================================
// Module   : tile_renderer
// Purpose  : Draws one grid cell's sprite as a stream of pixels with start/busy/done.
// Revision : 1.0 - initial release
// ============================================================================
module tile_renderer
    import render_pkg::*;
#(
    parameter int                  TILE_BITS = 4,
    parameter int                  GRID_BITS = 4,
    parameter int                  COLOUR_W  = 3,
    parameter logic [COLOUR_W-1:0] C_BG      = c_DEF_BG,
    parameter logic [COLOUR_W-1:0] C_WALL    = c_DEF_WALL,
    parameter logic [COLOUR_W-1:0] C_TANK1   = c_DEF_TANK1,
    parameter logic [COLOUR_W-1:0] C_TANK2   = c_DEF_TANK2,
    parameter logic [COLOUR_W-1:0] C_GUN     = c_DEF_GUN,
    parameter logic [COLOUR_W-1:0] C_PROJ    = c_DEF_PROJ
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           start,
    input  logic [2*GRID_BITS-1:0]         address,
    input  logic [7:0]                     position,
    output logic                           busy,
    output logic                           done,
    output logic [GRID_BITS+TILE_BITS-1:0] x,
    output logic [GRID_BITS+TILE_BITS-1:0] y,
    output logic [COLOUR_W-1:0]            colour,
    output logic                           plot
);

    localparam int TB = TILE_BITS;
    localparam logic [TB-1:0] c_ZERO     = '0;
    localparam logic [TB-1:0] c_MAX      = '1;
    localparam logic [TB-1:0] c_HALF     = {1'b1, {(TB-1){1'b0}}};
    localparam logic [TB-1:0] c_HALF_M1  = {1'b0, {(TB-1){1'b1}}};
    localparam logic [TB-1:0] c_QTR      = {2'b01, {(TB-2){1'b0}}};
    localparam logic [TB-1:0] c_QTR_M1   = {2'b00, {(TB-2){1'b1}}};
    localparam logic [TB-1:0] c_3QTR     = {2'b11, {(TB-2){1'b0}}};
    localparam logic [TB-1:0] c_3QTR_M1  = {2'b10, {(TB-2){1'b1}}};

    state_t                r_state;
    state_t                w_next_state;
    kind_t                 r_kind;
    kind_t                 w_in_kind;
    logic [1:0]            r_dir;
    logic [GRID_BITS-1:0]  r_col;
    logic [GRID_BITS-1:0]  r_row;
    logic [COLOUR_W-1:0]   r_colour;
    logic [COLOUR_W-1:0]   w_body_colour;
    logic                  r_plot;
    logic                  r_busy;
    logic                  r_done;
    logic                  w_load;
    logic                  w_step;
    logic                  w_last;
    logic [TB-1:0]         w_xs, w_xe, w_ys, w_ye;
    logic [TB-1:0]         w_xoff, w_yoff;
    logic                  w_unused;

    assign w_in_kind = decode_kind(position[7:4]);
    assign w_unused  = &{1'b0, position[3:2]};

    always_comb begin
        w_body_colour = C_BG;
        case (w_in_kind)
            KIND_WALL: w_body_colour = C_WALL;
            KIND_TANK: w_body_colour = position[c_BIT_TANK1] ? C_TANK1 : C_TANK2;
            KIND_PROJ: w_body_colour = C_PROJ;
            default:   w_body_colour = C_BG;
        endcase
    end

    // Next state plus the rectangle loaded into the scan counter on entry to BODY/GUN
    always_comb begin
        w_next_state = r_state;
        w_load       = 1'b0;
        w_step       = 1'b0;
        w_xs         = c_ZERO;
        w_xe         = c_MAX;
        w_ys         = c_ZERO;
        w_ye         = c_MAX;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_next_state = ST_BODY;
                    w_load       = 1'b1;
                    if (w_in_kind == KIND_TANK) begin
                        w_xs = c_QTR;     w_xe = c_3QTR_M1;
                        w_ys = c_QTR;     w_ye = c_3QTR_M1;
                    end else if (w_in_kind == KIND_PROJ) begin
                        w_xs = c_HALF_M1; w_xe = c_HALF;
                        w_ys = c_HALF_M1; w_ye = c_HALF;
                    end
                end
            end
            ST_BODY: begin
                if (!w_last) begin
                    w_step = 1'b1;
                end else if (r_kind == KIND_TANK) begin
                    w_next_state = ST_GUN;
                    w_load       = 1'b1;
                    case (r_dir)
                        c_DIR_UP: begin
                            w_xs = c_HALF; w_xe = c_HALF; w_ys = c_ZERO; w_ye = c_QTR_M1;
                        end
                        c_DIR_DOWN: begin
                            w_xs = c_HALF; w_xe = c_HALF; w_ys = c_3QTR; w_ye = c_MAX;
                        end
                        c_DIR_LEFT: begin
                            w_ys = c_HALF; w_ye = c_HALF; w_xs = c_ZERO; w_xe = c_QTR_M1;
                        end
                        default: begin
                            w_ys = c_HALF; w_ye = c_HALF; w_xs = c_3QTR; w_xe = c_MAX;
                        end
                    endcase
                end else begin
                    w_next_state = ST_DONE;
                end
            end
            ST_GUN: begin
                if (w_last) w_next_state = ST_DONE;
                else        w_step       = 1'b1;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_kind   <= KIND_EMPTY;
            r_dir    <= 2'b00;
            r_col    <= '0;
            r_row    <= '0;
            r_colour <= '0;
            r_plot   <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_plot  <= (w_next_state == ST_BODY) || (w_next_state == ST_GUN);
            r_busy  <= (w_next_state != ST_IDLE);
            r_done  <= (w_next_state == ST_DONE);
            if ((r_state == ST_IDLE) && start) begin
                r_col    <= address[GRID_BITS-1:0];
                r_row    <= address[2*GRID_BITS-1:GRID_BITS];
                r_kind   <= w_in_kind;
                r_dir    <= position[1:0];
                r_colour <= w_body_colour;
            end else if ((r_state == ST_BODY) && (w_next_state == ST_GUN)) begin
                r_colour <= C_GUN;
            end
        end
    end

    tile_scan_counter #(
        .W (TB)
    ) u_scan (
        .clock     (clock),
        .reset     (reset),
        .i_load    (w_load),
        .i_step    (w_step),
        .i_x_start (w_xs),
        .i_x_end   (w_xe),
        .i_y_start (w_ys),
        .i_y_end   (w_ye),
        .o_x       (w_xoff),
        .o_y       (w_yoff),
        .o_last    (w_last)
    );

    // Tile origin is column*T, so the screen coordinate is the column bits above the offset
    assign x      = {r_col, w_xoff};
    assign y      = {r_row, w_yoff};
    assign colour = r_colour;
    assign plot   = r_plot;
    assign busy   = r_busy;
    assign done   = r_done;

endmodule
`default_nettype wire

// File: tb/tb_tile_renderer.sv
`default_nettype none
// ============================================================================
// Module   : tb_tile_renderer
// Purpose  : Self-checking bench for tile_renderer (T=16, 16x16 grid).
// Revision : 1.0 - initial release
// ============================================================================
module tb_tile_renderer;

    localparam int c_T = 16;

    typedef struct packed {
        logic [7:0] px;
        logic [7:0] py;
        logic [2:0] pc;
    } pix_t;

    logic       clock;
    logic       reset;
    logic       start;
    logic [7:0] address;
    logic [7:0] position;
    logic       busy;
    logic       done;
    logic [7:0] x;
    logic [7:0] y;
    logic [2:0] colour;
    logic       plot;

    int   vectors;
    int   miscompares;
    pix_t sb[$];

    tile_renderer dut (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .address  (address),
        .position (position),
        .busy     (busy),
        .done     (done),
        .x        (x),
        .y        (y),
        .colour   (colour),
        .plot     (plot)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference model: expected pixel stream for one cell
    function automatic void model_push(input logic [7:0] addr, input logic [7:0] pos);
        int ox, oy, lo, hi;
        logic [2:0] c;
        ox = int'(addr[3:0]) * c_T;
        oy = int'(addr[7:4]) * c_T;
        if (pos[7] || pos[7:4] == 4'b0000) begin
            c = pos[7] ? 3'b011 : 3'b000;
            for (int j = 0; j < c_T; j++)
                for (int i = 0; i < c_T; i++)
                    sb.push_back('{px: 8'(ox + i), py: 8'(oy + j), pc: c});
        end else if (pos[6] || pos[5]) begin
            c = pos[6] ? 3'b101 : 3'b100;
            for (int j = c_T / 4; j < 3 * c_T / 4; j++)
                for (int i = c_T / 4; i < 3 * c_T / 4; i++)
                    sb.push_back('{px: 8'(ox + i), py: 8'(oy + j), pc: c});
            lo = (pos[1:0] == 2'b00 || pos[1:0] == 2'b10) ? 0 : 3 * c_T / 4;
            hi = lo + c_T / 4;
            for (int k = lo; k < hi; k++) begin
                if (pos[1] == 1'b0)
                    sb.push_back('{px: 8'(ox + c_T / 2), py: 8'(oy + k), pc: 3'b011});
                else
                    sb.push_back('{px: 8'(ox + k), py: 8'(oy + c_T / 2), pc: 3'b011});
            end
        end else begin
            for (int j = c_T / 2 - 1; j <= c_T / 2; j++)
                for (int i = c_T / 2 - 1; i <= c_T / 2; i++)
                    sb.push_back('{px: 8'(ox + i), py: 8'(oy + j), pc: 3'b110});
        end
    endfunction

    // Scoreboard consumer: every plotted pixel is compared with the next expected one
    always @(negedge clock) begin
        if (!reset && plot === 1'b1) begin
            pix_t e;
            vectors++;
            if (sb.size() == 0) begin
                miscompares++;
                $display("FAIL pixel_unexpected: got (%0d,%0d,c=%b), expected none", x, y, colour);
            end else begin
                e = sb.pop_front();
                if (x !== e.px || y !== e.py || colour !== e.pc) begin
                    miscompares++;
                    $display("FAIL pixel: got (%0d,%0d,c=%b), expected (%0d,%0d,c=%b)",
                             x, y, colour, e.px, e.py, e.pc);
                end
            end
        end
    end

    task automatic draw(input logic [7:0] addr, input logic [7:0] pos, input int n_exp, input string name);
        int cyc;
        model_push(addr, pos);
        @(negedge clock);
        start = 1'b1; address = addr; position = pos;
        @(negedge clock);
        start = 1'b0;
        cyc = 1;
        vectors++;
        if (busy !== 1'b1 || plot !== 1'b1) begin
            miscompares++;
            $display("FAIL %s first_cycle: busy=%b plot=%b, expected 1 1", name, busy, plot);
        end
        while (done !== 1'b1 && cyc < n_exp + 50) begin
            @(negedge clock);
            cyc++;
        end
        vectors++;
        if (cyc !== n_exp + 1) begin
            miscompares++;
            $display("FAIL %s done_cycle: got %0d, expected %0d", name, cyc, n_exp + 1);
        end
        vectors++;
        if (sb.size() != 0 || plot !== 1'b0) begin
            miscompares++;
            $display("FAIL %s pixels_left: got %0d plot=%b, expected 0 0", name, sb.size(), plot);
        end
        sb.delete();
        @(negedge clock);
        vectors++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL %s after_done: done=%b busy=%b, expected 0 0", name, done, busy);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; start = 1'b0; address = '0; position = '0;
        repeat (3) @(negedge clock);
        vectors++;
        if ({busy, done, plot, x, y, colour} !== 22'd0) begin
            miscompares++;
            $display("FAIL reset_values: got b%b d%b p%b x%0d y%0d c%b, expected all 0",
                     busy, done, plot, x, y, colour);
        end
        reset = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_wall;
        draw(8'h00, 8'h80, 256, "wall_00");
        draw(8'h12, 8'hF3, 256, "wall_priority");
    endtask

    task automatic test_tanks;
        draw(8'h21, 8'h43, 68, "tank1_right");
        draw(8'h00, 8'h20, 68, "tank2_up");
        draw(8'h00, 8'h61, 68, "tank_priority_down");
        draw(8'h5A, 8'h42, 68, "tank1_left");
    endtask

    task automatic test_proj_empty;
        draw(8'hFF, 8'h10, 4, "proj_ff");
        draw(8'hFF, 8'h00, 256, "empty_ff");
        vectors++;
        if (x !== 8'd255 || y !== 8'd255) begin
            miscompares++;
            $display("FAIL hold_last: got (%0d,%0d), expected (255,255)", x, y);
        end
    endtask

    task automatic test_back_to_back;
        int cyc;
        model_push(8'h00, 8'h80);
        model_push(8'h33, 8'h10);
        @(negedge clock);
        start = 1'b1; address = 8'h00; position = 8'h80;
        @(negedge clock);
        address = 8'h33; position = 8'h10;
        cyc = 1;
        while (done !== 1'b1 && cyc < 320) begin
            @(negedge clock);
            cyc++;
        end
        vectors++;
        if (cyc !== 257) begin
            miscompares++;
            $display("FAIL b2b done_cycle: got %0d, expected 257", cyc);
        end
        @(negedge clock);
        vectors++;
        if (plot !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b idle_gap: plot=%b busy=%b, expected 0 0", plot, busy);
        end
        @(negedge clock);
        start = 1'b0;
        vectors++;
        if (plot !== 1'b1) begin
            miscompares++;
            $display("FAIL b2b second_start: plot=%b, expected 1", plot);
        end
        cyc = 1;
        while (done !== 1'b1 && cyc < 40) begin
            @(negedge clock);
            cyc++;
        end
        vectors++;
        if (cyc !== 5 || sb.size() != 0) begin
            miscompares++;
            $display("FAIL b2b second_done: cycle %0d left %0d, expected 5 0", cyc, sb.size());
        end
        sb.delete();
        @(negedge clock);
    endtask

    task automatic test_reset_mid;
        int  cyc;
        bit  saw_done;
        model_push(8'h00, 8'h80);
        @(negedge clock);
        start = 1'b1; address = 8'h00; position = 8'h80;
        @(negedge clock);
        start = 1'b0;
        cyc = 1;
        while (cyc < 100) begin
            @(negedge clock);
            cyc++;
        end
        vectors++;
        if (busy !== 1'b1 || plot !== 1'b1) begin
            miscompares++;
            $display("FAIL midreset pre: busy=%b plot=%b, expected 1 1", busy, plot);
        end
        #1 reset = 1'b1;
        #1;
        vectors++;
        if ({busy, done, plot, x, y, colour} !== 22'd0) begin
            miscompares++;
            $display("FAIL midreset async: got b%b d%b p%b x%0d y%0d c%b, expected all 0",
                     busy, done, plot, x, y, colour);
        end
        @(negedge clock);
        reset = 1'b0;
        sb.delete();
        saw_done = 1'b0;
        repeat (6) begin
            @(negedge clock);
            if (done === 1'b1 || plot === 1'b1) saw_done = 1'b1;
        end
        vectors++;
        if (saw_done) begin
            miscompares++;
            $display("FAIL midreset quiet: activity after reset, expected none");
        end
        draw(8'h00, 8'h80, 256, "after_reset");
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_wall();
        test_tanks();
        test_proj_empty();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation still running at 1 ms, expected completion");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
